channel_scheduler: RTL and testbench
====================================

CHANNEL_SCHEDULER -- requirements
Module: channel_scheduler

Interface
REQ-001 The block SHALL have parameter CHANN, default 8, meaning the number of multiplexed channels (1..256).
REQ-002 The block SHALL have parameter QUOTA_W, default 8, meaning the width of the per-channel burst quota.
REQ-003 The block SHALL have parameter DEFAULT_QUOTA, default 32, meaning the quota every channel loads at reset.
REQ-004 The block SHALL have localparam CH_W = max(1, clog2(CHANN)), meaning the channel index width.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock for all logic.
REQ-006 The block SHALL have port com_rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 The block SHALL have port req, input, CHANN bits: per-channel "FIFO not empty", one bit per channel.
REQ-008 The block SHALL have port cfg_we, input, 1 bit: quota table write strobe.
REQ-009 The block SHALL have port cfg_chan, input, CH_W bits: quota table write index.
REQ-010 The block SHALL have port cfg_quota, input, QUOTA_W bits: quota value to write; 0 means the channel is disabled.
REQ-011 The block SHALL have port grant_valid, output, 1 bit: a grant is offered.
REQ-012 The block SHALL have port grant_ready, input, 1 bit: the multiplexer accepts the offered grant.
REQ-013 The block SHALL have port grant_chan, output, CH_W bits: the granted channel index.
REQ-014 The block SHALL have port grant_quota, output, QUOTA_W bits: the word budget of the grant.
REQ-015 The block SHALL have port beat, input, 1 bit: one data word of the active grant was transferred.
REQ-016 The block SHALL have port release, input, 1 bit: the multiplexer ends the burst early (for example, its FIFO ran empty).
REQ-017 The block SHALL have port burst_active, output, 1 bit: a grant is accepted and not yet finished.
REQ-018 The block SHALL have port remaining, output, QUOTA_W bits: the words left in the active burst.

Function
REQ-019 The block SHALL implement the FSM states IDLE, OFFER and ACTIVE.
REQ-020 In IDLE, when any channel is eligible (req=1 and quota!=0), the block SHALL pick one by round-robin starting at last_grant+1 mod CHANN, register it, and move to OFFER on the next cycle.
REQ-021 In OFFER, the block SHALL assert grant_valid; grant_chan and grant_quota SHALL stay stable until grant_ready is sampled high.
REQ-022 On grant_valid&&grant_ready, the block SHALL set remaining to grant_quota, set last_grant to grant_chan, and enter ACTIVE.
REQ-023 In ACTIVE, the block SHALL assert burst_active, decrement remaining on each beat, and ignore grant_ready.
REQ-024 ACTIVE SHALL end when beat occurs with remaining==1, or when release=1; the block SHALL then return to IDLE and deassert burst_active on the next cycle.
REQ-025 When beat and release are both high, the beat SHALL be counted and the burst SHALL end.
REQ-026 A beat or release outside ACTIVE SHALL be ignored.
REQ-027 The minimum time from the end of one burst to the next grant_valid SHALL be 2 cycles (IDLE, then OFFER).
REQ-028 If req of the offered channel drops while in OFFER, the offer SHALL NOT be withdrawn; the multiplexer handles an empty FIFO by using release.
REQ-029 A write of cfg_quota to any channel (including the active or offered channel) SHALL take effect on that channel's next selection; it SHALL NOT alter grant_quota or remaining in flight.
REQ-030 Quota 0 SHALL exclude the channel from selection; if no channel is eligible, the block SHALL remain in IDLE with grant_valid=0.
REQ-031 The round-robin pointer SHALL wrap from CHANN-1 to 0.
REQ-032 If only one channel is eligible, it SHALL be granted repeatedly.
REQ-033 The remaining counter SHALL never underflow.
REQ-034 A cfg_chan value >= CHANN SHALL be ignored.

Reset
REQ-035 com_rst SHALL asynchronously force: state=IDLE, grant_valid=0, burst_active=0, grant_chan=0, grant_quota=0, remaining=0, last_grant=CHANN-1 (so channel 0 has first priority), and all quota entries=DEFAULT_QUOTA.
REQ-036 Reset asserted mid-burst SHALL abort the burst immediately, with no further outputs until deassertion.
REQ-037 Deassertion SHALL be synchronised externally; the block SHALL not rely on any internal synchroniser.

Structure
REQ-038 Package channel_mux_pkg SHALL hold the FSM state enum, DEFAULT_QUOTA, and CONTROL_WORD 16'hc001 / CHANNEL_NUMBER_CONTROL 8'hab shared with the multiplexer.
REQ-039 The block SHALL contain one sub-module, rr_picker (parameter CHANN; inputs eligible[CHANN] and ptr; outputs found and index), purely combinational.
REQ-040 The quota table SHALL be a CHANN x QUOTA_W flop array, not a RAM.

Verification
REQ-041 Scenario: after reset, req=8'hFF, grant_ready=1, 32 beats per grant -> grants are issued to channels 0,1,...,7,0 in order, each with grant_quota=32.
REQ-042 Scenario: quota[2]=3 written, then req=8'h04 -> grant to chan 2 with quota 3; the third beat ends the burst, and grant_valid reasserts 2 cycles later.
REQ-043 Scenario: req=8'h11, quota[4]=0 -> only channel 0 is ever granted; grant_valid stays 0 when req=8'h10.
REQ-044 Scenario: in ACTIVE with remaining=10, beat and release are high together -> remaining=9 is not retained, burst_active=0 next cycle, and the next grant goes to the next eligible channel.
REQ-045 Scenario: grant_ready held 0 for 5 cycles in OFFER while req drops -> grant_chan and grant_quota stay stable and grant_valid stays 1 until accepted.
REQ-046 Scenario: com_rst pulsed mid-burst -> all outputs are at reset values within the same cycle, and the quota table returns to 32.

Source files
------------

// File: rtl/channel_mux_pkg.sv
// ============================================================================
// Module      : channel_mux_pkg
// Description : Shared types and constants for the channel scheduler and the
//               channel multiplexer it serves.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package channel_mux_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_OFFER  = 2'd1,
        ST_ACTIVE = 2'd2
    } sched_state_t;

    localparam int          DEFAULT_QUOTA          = 32;
    localparam logic [15:0] CONTROL_WORD           = 16'hc001;
    localparam logic [7:0]  CHANNEL_NUMBER_CONTROL = 8'hab;

endpackage

`default_nettype wire

// File: rtl/rr_picker.sv
// ============================================================================
// Module      : rr_picker
// Description : Combinational round-robin picker; returns the first eligible
//               channel at or after ptr, wrapping modulo CHANN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_picker #(
    parameter  int CHANN = 8,
    localparam int CH_W  = (CHANN > 1) ? $clog2(CHANN) : 1
) (
    input  logic [CHANN-1:0] eligible,
    input  logic [CH_W-1:0]  ptr,
    output logic             found,
    output logic [CH_W-1:0]  index
);

    logic [CHANN-1:0] w_rot;
    logic [CH_W:0]    w_sum;

    // Rotate so that bit 0 corresponds to the channel at ptr.
    assign w_rot = CHANN'({eligible, eligible} >> ptr);

    always_comb begin
        found = 1'b0;
        w_sum = '0;
        // Descending scan: the lowest rotated position is the last to write.
        for (int i = CHANN - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                found = 1'b1;
                w_sum = {1'b0, ptr} + (CH_W + 1)'(i);
            end
        end
        if (w_sum >= (CH_W + 1)'(CHANN)) begin
            w_sum = w_sum - (CH_W + 1)'(CHANN);
        end
        index = w_sum[CH_W-1:0];
    end

endmodule

`default_nettype wire

// File: rtl/channel_scheduler.sv
// ============================================================================
// Module      : channel_scheduler
// Description : Round-robin burst scheduler with per-channel quota table;
//               offers one channel at a time and tracks the accepted burst.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module channel_scheduler
    import channel_mux_pkg::*;
#(
    parameter  int CHANN         = 8,
    parameter  int QUOTA_W       = 8,
    parameter  int DEFAULT_QUOTA = channel_mux_pkg::DEFAULT_QUOTA,
    localparam int CH_W          = (CHANN > 1) ? $clog2(CHANN) : 1
) (
    input  logic               clk,
    input  logic               com_rst,
    input  logic [CHANN-1:0]   req,
    input  logic               cfg_we,
    input  logic [CH_W-1:0]    cfg_chan,
    input  logic [QUOTA_W-1:0] cfg_quota,
    output logic               grant_valid,
    input  logic               grant_ready,
    output logic [CH_W-1:0]    grant_chan,
    output logic [QUOTA_W-1:0] grant_quota,
    input  logic               beat,
    input  logic               release_req,
    output logic               burst_active,
    output logic [QUOTA_W-1:0] remaining
);

    localparam logic [QUOTA_W-1:0] c_q_one   = QUOTA_W'(1);
    localparam logic [QUOTA_W-1:0] c_q_rst   = QUOTA_W'(DEFAULT_QUOTA);
    localparam logic [CH_W-1:0]    c_ch_one  = CH_W'(1);
    localparam logic [CH_W-1:0]    c_ch_last = CH_W'(CHANN - 1);

    sched_state_t       r_state;
    sched_state_t       w_state_next;
    logic [CH_W-1:0]    r_grant_chan;
    logic [CH_W-1:0]    w_chan_next;
    logic [QUOTA_W-1:0] r_grant_quota;
    logic [QUOTA_W-1:0] w_gq_next;
    logic [QUOTA_W-1:0] r_remaining;
    logic [QUOTA_W-1:0] w_rem_next;
    logic [CH_W-1:0]    r_last_grant;
    logic [CH_W-1:0]    w_last_next;
    logic [QUOTA_W-1:0] r_quota [CHANN];

    logic [CHANN-1:0]   w_eligible;
    logic [CH_W-1:0]    w_ptr;
    logic               w_found;
    logic [CH_W-1:0]    w_pick;

    // Quota table: one flop row per channel; out-of-range indices match no row.
    for (genvar gi = 0; gi < CHANN; gi++) begin : g_quota
        always_ff @(posedge clk or posedge com_rst) begin
            if (com_rst) begin
                r_quota[gi] <= c_q_rst;
            end else if (cfg_we && (cfg_chan == CH_W'(gi))) begin
                r_quota[gi] <= cfg_quota;
            end
        end

        assign w_eligible[gi] = req[gi] && (r_quota[gi] != '0);
    end

    assign w_ptr = (r_last_grant == c_ch_last) ? '0 : r_last_grant + c_ch_one;

    rr_picker #(
        .CHANN    (CHANN)
    ) u_rr_picker (
        .eligible (w_eligible),
        .ptr      (w_ptr),
        .found    (w_found),
        .index    (w_pick)
    );

    always_comb begin
        w_state_next = r_state;
        w_chan_next  = r_grant_chan;
        w_gq_next    = r_grant_quota;
        w_rem_next   = r_remaining;
        w_last_next  = r_last_grant;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_next = ST_OFFER;
                    w_chan_next  = w_pick;
                    w_gq_next    = r_quota[w_pick];
                end
            end
            ST_OFFER: begin
                if (grant_ready) begin
                    w_state_next = ST_ACTIVE;
                    w_rem_next   = r_grant_quota;
                    w_last_next  = r_grant_chan;
                end
            end
            ST_ACTIVE: begin
                if (beat && (r_remaining != '0)) begin
                    w_rem_next = r_remaining - c_q_one;
                end
                // A beat coinciding with release is counted, then the burst closes.
                if (release_req || (beat && (r_remaining == c_q_one))) begin
                    w_state_next = ST_IDLE;
                    w_rem_next   = '0;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge com_rst) begin
        if (com_rst) begin
            r_state       <= ST_IDLE;
            r_grant_chan  <= '0;
            r_grant_quota <= '0;
            r_remaining   <= '0;
            r_last_grant  <= c_ch_last;
        end else begin
            r_state       <= w_state_next;
            r_grant_chan  <= w_chan_next;
            r_grant_quota <= w_gq_next;
            r_remaining   <= w_rem_next;
            r_last_grant  <= w_last_next;
        end
    end

    assign grant_valid  = (r_state == ST_OFFER);
    assign burst_active = (r_state == ST_ACTIVE);
    assign grant_chan   = r_grant_chan;
    assign grant_quota  = r_grant_quota;
    assign remaining    = r_remaining;

endmodule

`default_nettype wire

// File: tb/tb_channel_scheduler.sv
// ============================================================================
// Module      : tb_channel_scheduler
// Description : Directed scoreboard bench for channel_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_channel_scheduler;

    logic       clk = 1'b0;
    logic       com_rst;
    logic [7:0] req;
    logic       cfg_we;
    logic [2:0] cfg_chan;
    logic [7:0] cfg_quota;
    logic       grant_valid;
    logic       grant_ready;
    logic [2:0] grant_chan;
    logic [7:0] grant_quota;
    logic       beat;
    logic       release_req;
    logic       burst_active;
    logic [7:0] remaining;

    typedef struct packed {
        logic [2:0] ch;
        logic [7:0] q;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    channel_scheduler #(
        .CHANN         (8),
        .QUOTA_W       (8),
        .DEFAULT_QUOTA (32)
    ) dut (
        .clk          (clk),
        .com_rst      (com_rst),
        .req          (req),
        .cfg_we       (cfg_we),
        .cfg_chan     (cfg_chan),
        .cfg_quota    (cfg_quota),
        .grant_valid  (grant_valid),
        .grant_ready  (grant_ready),
        .grant_chan   (grant_chan),
        .grant_quota  (grant_quota),
        .beat         (beat),
        .release_req  (release_req),
        .burst_active (burst_active),
        .remaining    (remaining)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int ch, input int q);
        exp_t e;
        e.ch = 3'(ch);
        e.q  = 8'(q);
        sb.push_back(e);
    endtask

    task automatic write_quota(input int ch, input int q);
        cfg_we    = 1'b1;
        cfg_chan  = 3'(ch);
        cfg_quota = 8'(q);
        tick();
        cfg_we    = 1'b0;
    endtask

    task automatic wait_grant();
        int k = 0;
        while ((grant_valid !== 1'b1) && (k < 40)) begin
            tick();
            k++;
        end
        if (grant_valid !== 1'b1) check("grant_timeout", 32'(grant_valid), 32'd1);
    endtask

    task automatic accept();
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_underflow", 32'(sb.size()), 32'd1);
            return;
        end
        e = sb.pop_front();
        check("grant_chan", 32'(grant_chan), 32'(e.ch));
        check("grant_quota", 32'(grant_quota), 32'(e.q));
        grant_ready = 1'b1;
        tick();
        grant_ready = 1'b0;
        check("burst_active_on", 32'(burst_active), 32'd1);
        check("remaining_load", 32'(remaining), 32'(e.q));
    endtask

    task automatic beats(input int n);
        beat = 1'b1;
        repeat (n) tick();
        beat = 1'b0;
    endtask

    task automatic end_release();
        release_req = 1'b1;
        tick();
        release_req = 1'b0;
        check("release_end", 32'(burst_active), 32'd0);
        check("release_rem", 32'(remaining), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        com_rst = 1'b1; req = '0; cfg_we = 1'b0; cfg_chan = '0; cfg_quota = '0;
        grant_ready = 1'b0; beat = 1'b0; release_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_grant_valid", 32'(grant_valid), 32'd0);
        check("rst_burst_active", 32'(burst_active), 32'd0);
        check("rst_grant_chan", 32'(grant_chan), 32'd0);
        check("rst_grant_quota", 32'(grant_quota), 32'd0);
        check("rst_remaining", 32'(remaining), 32'd0);
        com_rst = 1'b0;
        tick();

        // Full round robin 0..7 then wrap to 0, default quota 32.
        req = 8'hFF;
        for (int i = 0; i < 9; i++) push(i % 8, 32);
        for (int i = 0; i < 9; i++) begin
            wait_grant();
            accept();
            beats(31);
            check("rr_rem_last", 32'(remaining), 32'd1);
            if (i == 8) req = 8'h00;
            beats(1);
            check("rr_burst_end", 32'(burst_active), 32'd0);
            check("rr_rem_zero", 32'(remaining), 32'd0);
            check("rr_idle_gap", 32'(grant_valid), 32'd0);
        end
        repeat (3) tick();
        check("no_req_idle", 32'(grant_valid), 32'd0);

        // Short quota on channel 2, in-flight quota write, 2-cycle regrant.
        write_quota(2, 3);
        req = 8'h04;
        push(2, 3);
        wait_grant();
        accept();
        beats(1);
        write_quota(2, 5);
        check("inflight_gq", 32'(grant_quota), 32'd3);
        check("inflight_rem", 32'(remaining), 32'd2);
        beats(2);
        check("q3_end", 32'(burst_active), 32'd0);
        check("q3_gap", 32'(grant_valid), 32'd0);
        tick();
        check("q3_revalid", 32'(grant_valid), 32'd1);
        push(2, 5);
        accept();
        req = 8'h00;
        end_release();

        // Quota 0 excludes channel 4.
        write_quota(4, 0);
        req = 8'h11;
        push(0, 32);
        wait_grant();
        accept();
        end_release();
        push(0, 32);
        wait_grant();
        accept();
        req = 8'h10;
        end_release();
        repeat (4) tick();
        check("quota0_excluded", 32'(grant_valid), 32'd0);

        // Beat and release together end the burst.
        write_quota(1, 10);
        req = 8'h06;
        push(1, 10);
        wait_grant();
        accept();
        beat = 1'b1;
        release_req = 1'b1;
        tick();
        beat = 1'b0;
        release_req = 1'b0;
        check("beat_rel_end", 32'(burst_active), 32'd0);
        check("beat_rel_rem", 32'(remaining), 32'd0);
        push(2, 5);
        wait_grant();
        accept();
        req = 8'h00;
        end_release();

        // Offer held stable while req drops and grant_ready stays low.
        req = 8'h08;
        push(3, 32);
        wait_grant();
        req = 8'h00;
        repeat (5) begin
            tick();
            check("hold_valid", 32'(grant_valid), 32'd1);
            check("hold_chan", 32'(grant_chan), 32'd3);
            check("hold_quota", 32'(grant_quota), 32'd32);
        end
        accept();
        beats(2);
        check("pre_rst_rem", 32'(remaining), 32'd30);

        // Asynchronous reset mid-burst.
        com_rst = 1'b1;
        #1;
        check("arst_burst_active", 32'(burst_active), 32'd0);
        check("arst_grant_valid", 32'(grant_valid), 32'd0);
        check("arst_grant_chan", 32'(grant_chan), 32'd0);
        check("arst_grant_quota", 32'(grant_quota), 32'd0);
        check("arst_remaining", 32'(remaining), 32'd0);
        tick();
        com_rst = 1'b0;
        req = 8'h16;
        push(1, 32);
        push(2, 32);
        push(4, 32);
        for (int i = 0; i < 3; i++) begin
            wait_grant();
            accept();
            if (i == 2) req = 8'h00;
            end_release();
        end
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
